// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Button-driven settings controller for the digital clock core. Three
//   debounced buttons walk a set-time / set-alarm state machine. Time edits
//   start from the live clock value and are handed to the core with a
//   one-cycle load strobe. Alarm edits are held on the alarm outputs until the
//   next alarm commit.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_mode   in   enter time edit from IDLE / abort any edit
//   btn_inc    in   increment active field (auto-repeats while held)
//   btn_ok     in   advance field / commit; enter alarm edit from IDLE
//   cur_h/m/s  in   live time from the clock core
//   set_h/m/s  out  time to load, valid while load_time is high
//   load_time  out  one-cycle strobe after a time commit
//   alarm_h/m  out  last committed alarm
//   alarm_en   out  high once any alarm has been committed
//   edit_field out  current state encoding, used for display blinking

module clock_set_ctrl #(
    parameter int H_MOD      = 12,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_ok,
    input  logic [3:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    output logic [3:0] set_h,
    output logic [5:0] set_m,
    output logic [5:0] set_s,
    output logic       load_time,
    output logic [3:0] alarm_h,
    output logic [5:0] alarm_m,
    output logic       alarm_en,
    output logic [2:0] edit_field
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        SET_S = 3'd3,
        AL_H  = 3'd4,
        AL_M  = 3'd5
    } state_t;

    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    H_MAX  = 4'(H_MOD - 1);
    localparam logic [4:0]    H_LIM  = 5'(H_MOD);
    localparam logic [5:0]    MS_MAX = 6'd59;
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PER);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_ONE = TW'(1);

    state_t        state, state_n;
    logic          mode_prev, inc_prev, ok_prev;
    logic          mode_p, inc_p, ok_p;
    logic [3:0]    ed_h, ed_h_n;
    logic [5:0]    ed_m, ed_m_n, ed_s, ed_s_n;
    logic [RW-1:0] rep_cnt, rep_n;
    logic          repeating, rpt_n;
    logic [TW-1:0] to_cnt, to_n;
    logic [3:0]    set_h_n, alarm_h_n;
    logic [5:0]    set_m_n, set_s_n, alarm_m_n;
    logic          load_n, alen_n;
    logic          rep_fire, do_inc;

    // A press is the first cycle a button is seen high. The history registers
    // reset high so a button held through reset must be released first.
    assign mode_p = btn_mode & ~mode_prev;
    assign inc_p  = btn_inc  & ~inc_prev;
    assign ok_p   = btn_ok   & ~ok_prev;

    assign edit_field = state;

    // All state lives in one register bank; the next values are computed
    // combinationally below so every output change lands one cycle after the
    // press that caused it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
            ok_prev   <= 1'b1;
            ed_h      <= '0;
            ed_m      <= '0;
            ed_s      <= '0;
            rep_cnt   <= '0;
            repeating <= 1'b0;
            to_cnt    <= '0;
            set_h     <= '0;
            set_m     <= '0;
            set_s     <= '0;
            load_time <= 1'b0;
            alarm_h   <= '0;
            alarm_m   <= '0;
            alarm_en  <= 1'b0;
        end else begin
            state     <= state_n;
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            ok_prev   <= btn_ok;
            ed_h      <= ed_h_n;
            ed_m      <= ed_m_n;
            ed_s      <= ed_s_n;
            rep_cnt   <= rep_n;
            repeating <= rpt_n;
            to_cnt    <= to_n;
            set_h     <= set_h_n;
            set_m     <= set_m_n;
            set_s     <= set_s_n;
            load_time <= load_n;
            alarm_h   <= alarm_h_n;
            alarm_m   <= alarm_m_n;
            alarm_en  <= alen_n;
        end
    end

    // Next-state and datapath logic. Button priority is mode > ok > inc.
    // The repeat counter measures how long btn_inc has been held since its
    // press: the first auto-increment comes after REPEAT_DLY cycles, later
    // ones every REPEAT_PER. The idle counter aborts an edit that sees no
    // activity for TIMEOUT cycles; auto-repeat increments count as activity.
    always_comb begin
        state_n   = state;
        ed_h_n    = ed_h;
        ed_m_n    = ed_m;
        ed_s_n    = ed_s;
        rep_n     = rep_cnt;
        rpt_n     = repeating;
        to_n      = to_cnt;
        set_h_n   = set_h;
        set_m_n   = set_m;
        set_s_n   = set_s;
        load_n    = 1'b0;
        alarm_h_n = alarm_h;
        alarm_m_n = alarm_m;
        alen_n    = alarm_en;
        rep_fire  = 1'b0;
        do_inc    = 1'b0;

        if (state == IDLE) begin
            rep_n = '0;
            rpt_n = 1'b0;
            to_n  = '0;
            if (mode_p) begin
                // Out-of-range live values are clamped so editing always
                // starts from a legal field value.
                ed_h_n  = ({1'b0, cur_h} >= H_LIM) ? 4'd0 : cur_h;
                ed_m_n  = (cur_m > MS_MAX) ? 6'd0 : cur_m;
                ed_s_n  = (cur_s > MS_MAX) ? 6'd0 : cur_s;
                state_n = SET_H;
            end else if (ok_p) begin
                ed_h_n  = alarm_h;
                ed_m_n  = alarm_m;
                state_n = AL_H;
            end
        end else begin
            to_n = to_cnt + TO_ONE;

            if (btn_inc && !inc_p) begin
                rep_n = rep_cnt + R_ONE;
                if (rep_n == (repeating ? R_PER : R_DLY)) begin
                    rep_fire = 1'b1;
                    rep_n    = '0;
                    rpt_n    = 1'b1;
                end
            end else begin
                rep_n = '0;
                rpt_n = 1'b0;
            end

            if (mode_p) begin
                state_n = IDLE;
            end else if (ok_p) begin
                to_n  = '0;
                rep_n = '0;
                rpt_n = 1'b0;
                case (state)
                    SET_H: state_n = SET_M;
                    SET_M: state_n = SET_S;
                    SET_S: begin
                        set_h_n = ed_h;
                        set_m_n = ed_m;
                        set_s_n = ed_s;
                        load_n  = 1'b1;
                        state_n = IDLE;
                    end
                    AL_H: state_n = AL_M;
                    AL_M: begin
                        alarm_h_n = ed_h;
                        alarm_m_n = ed_m;
                        alen_n    = 1'b1;
                        state_n   = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end else if (inc_p || rep_fire) begin
                do_inc = 1'b1;
                to_n   = '0;
            end else if (to_n == TO_LIM) begin
                state_n = IDLE;
            end
        end

        // Field increment with wrap; hours wrap at H_MOD, minutes and
        // seconds at 60.
        if (do_inc) begin
            case (state)
                SET_H, AL_H: ed_h_n = (ed_h == H_MAX)  ? 4'd0 : ed_h + 4'd1;
                SET_M, AL_M: ed_m_n = (ed_m == MS_MAX) ? 6'd0 : ed_m + 6'd1;
                SET_S:       ed_s_n = (ed_s == MS_MAX) ? 6'd0 : ed_s + 6'd1;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
//   Self-checking bench for clock_set_ctrl. Button sequences come from a
//   vector table plus a few hand-written multi-cycle sequences. Each expected
//   time commit is queued when its ok press is driven and compared when
//   load_time is seen.

module tb_clock_set_ctrl;

    localparam int H_MOD      = 12;
    localparam int REPEAT_DLY = 500;
    localparam int REPEAT_PER = 100;
    localparam int TIMEOUT    = 10000;

    typedef struct {
        logic [3:0] ch;
        logic [5:0] cm;
        logic [5:0] cs;
        logic       mode;
        logic       inc;
        logic       ok;
        int         reps;
        logic [2:0] expField;
        logic       commit;
        logic [3:0] eh;
        logic [5:0] em;
        logic [5:0] es;
    } vec_t;

    typedef struct {
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } load_t;

    logic       clk;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_ok;
    logic [3:0] cur_h, set_h, alarm_h;
    logic [5:0] cur_m, cur_s, set_m, set_s, alarm_m;
    logic       load_time, alarm_en;
    logic [2:0] edit_field;

    int    assertCount = 0;
    int    failCount   = 0;
    load_t sbQ[$];
    vec_t  vecs[$];

    clock_set_ctrl #(
        .H_MOD(H_MOD),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_ok(btn_ok),
        .cur_h(cur_h),
        .cur_m(cur_m),
        .cur_s(cur_s),
        .set_h(set_h),
        .set_m(set_m),
        .set_s(set_s),
        .load_time(load_time),
        .alarm_h(alarm_h),
        .alarm_m(alarm_m),
        .alarm_en(alarm_en),
        .edit_field(edit_field)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input int ch, input int cm, input int cs,
                                   input int md, input int ic, input int ok,
                                   input int reps, input int ef, input int cmt,
                                   input int eh, input int em, input int es);
        vec_t t;
        t.ch       = 4'(ch);
        t.cm       = 6'(cm);
        t.cs       = 6'(cs);
        t.mode     = md[0];
        t.inc      = ic[0];
        t.ok       = ok[0];
        t.reps     = reps;
        t.expField = 3'(ef);
        t.commit   = cmt[0];
        t.eh       = 4'(eh);
        t.em       = 6'(em);
        t.es       = 6'(es);
        return t;
    endfunction

    // Drives one row: pulse the selected buttons for one cycle 'reps' times,
    // checking the state encoding after each pulse. A commit row queues the
    // time the core should be handed.
    task automatic applyStimulus(input vec_t v, input string tag);
        cur_h = v.ch;
        cur_m = v.cm;
        cur_s = v.cs;
        for (int r = 0; r < v.reps; r++) begin
            @(negedge clk);
            btn_mode = v.mode;
            btn_inc  = v.inc;
            btn_ok   = v.ok;
            if (v.commit) sbQ.push_back('{v.eh, v.em, v.es});
            @(negedge clk);
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            btn_ok   = 1'b0;
            checkOutput($sformatf("%s edit_field", tag), edit_field, v.expField);
        end
    endtask

    // Scoreboard monitor: every load_time cycle must match the oldest queued
    // commit; a strobe with nothing queued is an unexpected load.
    always @(negedge clk) begin
        if (rst_n && load_time) begin
            if (sbQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected load_time: got 1, expected 0");
            end else begin
                load_t e;
                e = sbQ.pop_front();
                checkOutput("load set_h", set_h, e.h);
                checkOutput("load set_m", set_m, e.m);
                checkOutput("load set_s", set_s, e.s);
            end
        end
    end

    // Main sequence: reset checks, table vectors, then the multi-cycle cases.
    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        btn_ok   = 1'b0;
        cur_h    = 4'd3;
        cur_m    = 6'd7;
        cur_s    = 6'd8;

        repeat (3) @(negedge clk);
        checkOutput("reset edit_field", edit_field, 0);
        checkOutput("reset load_time", load_time, 0);
        checkOutput("reset set_h", set_h, 0);
        checkOutput("reset set_m", set_m, 0);
        checkOutput("reset set_s", set_s, 0);
        checkOutput("reset alarm_h", alarm_h, 0);
        checkOutput("reset alarm_m", alarm_m, 0);
        checkOutput("reset alarm_en", alarm_en, 0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("held mode no press", edit_field, 0);
        btn_mode = 1'b0;

        applyStimulus(mkVec(3, 7, 8, 1, 1, 0, 1, 1, 0, 0, 0, 0), "rst mode");
        applyStimulus(mkVec(3, 7, 8, 0, 1, 0, 1, 1, 0, 0, 0, 0), "rst inc");
        applyStimulus(mkVec(3, 7, 8, 0, 0, 1, 1, 2, 0, 0, 0, 0), "rst ok1");
        applyStimulus(mkVec(3, 7, 8, 0, 0, 1, 1, 3, 0, 0, 0, 0), "rst ok2");
        applyStimulus(mkVec(3, 7, 8, 0, 0, 1, 1, 0, 1, 4, 7, 8), "rst commit");

        vecs.push_back(mkVec(5, 58, 20, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(5, 58, 20, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(5, 58, 20, 0, 0, 1, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mkVec(5, 58, 20, 0, 1, 0, 3, 2, 0, 0, 0, 0));
        vecs.push_back(mkVec(5, 58, 20, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mkVec(5, 58, 20, 0, 0, 1, 1, 0, 1, 6, 1, 20));
        vecs.push_back(mkVec(11, 59, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(11, 59, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(11, 59, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mkVec(11, 59, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mkVec(11, 59, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mkVec(11, 59, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mkVec(14, 63, 61, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(14, 63, 61, 0, 0, 1, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mkVec(14, 63, 61, 0, 1, 0, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mkVec(14, 63, 61, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mkVec(14, 63, 61, 0, 1, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mkVec(14, 63, 61, 0, 0, 1, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 3, 4, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 20, 5, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

        checkOutput("alarm_en before commit", alarm_en, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end
        checkOutput("alarm_h", alarm_h, 3);
        checkOutput("alarm_m", alarm_m, 20);
        checkOutput("alarm_en", alarm_en, 1);

        // Auto-repeat: hold inc in SET_S well past the fourth repeat point
        // but short of a fifth; press + 4 repeats takes 0 to 5.
        applyStimulus(mkVec(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0), "rpt mode");
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0), "rpt ok1");
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0), "rpt ok2");
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (REPEAT_DLY + 3 * REPEAT_PER + REPEAT_PER / 2) @(negedge clk);
        btn_inc = 1'b0;
        checkOutput("rpt still SET_S", edit_field, 3);
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 5), "rpt commit");

        // Mode and ok together in SET_M: mode wins, nothing committed.
        applyStimulus(mkVec(7, 8, 9, 1, 0, 0, 1, 1, 0, 0, 0, 0), "abort mode");
        applyStimulus(mkVec(7, 8, 9, 0, 0, 1, 1, 2, 0, 0, 0, 0), "abort ok");
        applyStimulus(mkVec(7, 8, 9, 1, 0, 1, 1, 0, 0, 0, 0, 0), "abort both");
        checkOutput("abort set_h", set_h, 0);
        checkOutput("abort set_s", set_s, 5);

        // Idle timeout out of SET_H.
        applyStimulus(mkVec(9, 30, 40, 1, 0, 0, 1, 1, 0, 0, 0, 0), "to mode");
        repeat (TIMEOUT - 5) @(negedge clk);
        checkOutput("before timeout", edit_field, 1);
        repeat (10) @(negedge clk);
        checkOutput("after timeout", edit_field, 0);
        checkOutput("timeout set_h", set_h, 0);
        checkOutput("timeout set_m", set_m, 0);
        checkOutput("timeout set_s", set_s, 5);

        // Reset asserted mid alarm edit clears everything at once.
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0), "mid al ok1");
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0), "mid al ok2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst edit_field", edit_field, 0);
        checkOutput("midrst alarm_en", alarm_en, 0);
        checkOutput("midrst alarm_h", alarm_h, 0);
        checkOutput("midrst alarm_m", alarm_m, 0);
        checkOutput("midrst set_s", set_s, 0);
        checkOutput("midrst load_time", load_time, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("pending loads", sbQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- User-interface controller that writes time and alarm settings into the digital clock core (drives its time-load and alarm inputs).
- Three buttons navigate a set-time/set-alarm state machine; current clock time is read back so editing starts from the live value.
- A committed time is presented with a one-cycle load strobe; alarm values are held until the next commit.

Parameters:
- H_MOD, 12, hour modulus; hour field counts 0..H_MOD-1; legal range 2..16.
- REPEAT_DLY, 500, cycles btn_inc must be held before auto-repeat starts.
- REPEAT_PER, 100, cycles between auto-repeat increments once repeating.
- TIMEOUT, 10000, idle cycles in any edit state before abort to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_mode  in  1  synchronous, debounced level; enter time edit / abort.
- btn_inc  in  1  synchronous, debounced level; increment current field.
- btn_ok  in  1  synchronous, debounced level; advance/commit; enter alarm edit from IDLE.
- cur_h  in  4  live hours from clock core.
- cur_m  in  6  live minutes.
- cur_s  in  6  live seconds.
- set_h  out  4  time value to load, hours.
- set_m  out  6  time value to load, minutes.
- set_s  out  6  time value to load, seconds.
- load_time  out  1  one-cycle strobe; set_h/m/s valid in that cycle.
- alarm_h  out  4  committed alarm hour.
- alarm_m  out  6  committed alarm minute.
- alarm_en  out  1  high once any alarm has been committed.
- edit_field  out  3  current state encoding (for display blinking).

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, edit registers 0, timers 0. Button history registers reset to 1, so buttons held through reset produce no press until released and re-pressed.
- Press = rising edge: btn & ~btn_prev, evaluated each cycle. Priority when several press in one cycle: mode > ok > inc.
- States and edit_field encoding: IDLE=0, SET_H=1, SET_M=2, SET_S=3, AL_H=4, AL_M=5.
- IDLE:
  - mode press: capture cur_h/m/s into edit regs, go to SET_H.
  - ok press: copy alarm_h/m into edit regs, go to AL_H.
  - inc ignored.
- SET_H, then SET_M, then SET_S, each on an ok press.
- ok press in SET_S:
  - set_h/m/s take the edit regs.
  - load_time=1 for exactly the next cycle.
  - go to IDLE.
- AL_H goes to AL_M on ok press.
- ok press in AL_M: alarm_h/m take the edit regs; alarm_en=1; go to IDLE. No load_time.
- mode press in any edit state: abort to IDLE; no outputs change.
- inc press in an edit state increments the active field with wrap:
  - hours H_MOD-1 to 0.
  - minutes/seconds 59 to 0.
  - Out-of-range captured values (e.g. cur_m=63) are clamped to 0 on capture.
- Auto-repeat:
  - btn_inc held continuously REPEAT_DLY cycles after its press gives one extra increment.
  - Then one increment every REPEAT_PER cycles while held.
  - Release clears the repeat counter.
  - A state change also clears it.
- Timeout:
  - Counter clears on any press and on entering an edit state.
  - Reaching TIMEOUT in an edit state aborts to IDLE with no commit.
  - Auto-repeat increments count as activity.
- load_time is never asserted outside the cycle after a SET_S commit.
- set_h/m/s hold their last committed value between commits.
- Reset mid-edit: edits discarded, alarm_en cleared, no strobe.
- Latency: press seen on cycle N gives state/field update visible at cycle N+1 outputs.

Test Plan:
- Reset with btn_inc held high, then release and press once in SET_H (cur_h=3): no increment while held through reset; single press gives edit hour 4.
- cur_h=5, cur_m=58, cur_s=20; sequence mode, inc, ok, inc×3, ok, ok -> exactly one load_time pulse with set_h=6, set_m=1 (58→61 wraps: 59,0,1), set_s=20; edit_field back to 0.
- In SET_H at 11 with H_MOD=12, inc -> 0. In SET_M from 59, inc -> 0.
- IDLE ok, inc×3 (alarm starts 0 → 3), ok, inc×20, ok -> alarm_h=3, alarm_m=20, alarm_en=1, load_time never pulses.
- Hold btn_inc in SET_S (start 0) for REPEAT_DLY+3×REPEAT_PER cycles -> value 5 (press + 1 + 3). Mode and ok pressed in same cycle in SET_M -> abort to IDLE, no commit.
- Enter SET_H, no buttons for TIMEOUT cycles -> IDLE, set_* unchanged, no load_time. Assert rst_n=0 mid-AL_M -> all outputs 0 immediately.
